// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter advanced by rising edges of the divided slow clock.
// The slow clock is synchronised as data; a validated load port sets the time.
module time_keeper #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slw_clk,
  input  logic       run,
  input  logic       set_load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       day_wrap,
  output logic       set_err
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   rise;
  logic                   tick_q;

  logic [7:0] nxt_hh, nxt_mm, nxt_ss;
  logic       ss_wrap, mm_wrap, hh_wrap;
  logic       load_valid;

  assign armed = (arm_cnt == ARM_CYCLES[ARM_W-1:0]);
  assign rise  = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Registering the detected edge keeps the tick off the synchroniser's output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      arm_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slw_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
      if (!armed)
        arm_cnt <= arm_cnt + 1'b1;
      tick_q <= rise & armed;
    end
  end

  always_comb begin
    nxt_hh  = hh;
    nxt_mm  = mm;
    nxt_ss  = ss;
    ss_wrap = 1'b0;
    mm_wrap = 1'b0;
    hh_wrap = 1'b0;

    if (ss[3:0] == 4'd9) begin
      nxt_ss[3:0] = 4'd0;
      if (ss[7:4] == 4'd5) begin
        nxt_ss[7:4] = 4'd0;
        ss_wrap     = 1'b1;
      end else begin
        nxt_ss[7:4] = ss[7:4] + 4'd1;
      end
    end else begin
      nxt_ss[3:0] = ss[3:0] + 4'd1;
    end

    if (ss_wrap) begin
      if (mm[3:0] == 4'd9) begin
        nxt_mm[3:0] = 4'd0;
        if (mm[7:4] == 4'd5) begin
          nxt_mm[7:4] = 4'd0;
          mm_wrap     = 1'b1;
        end else begin
          nxt_mm[7:4] = mm[7:4] + 4'd1;
        end
      end else begin
        nxt_mm[3:0] = mm[3:0] + 4'd1;
      end
    end

    if (mm_wrap) begin
      if (hh == 8'h23) begin
        nxt_hh  = 8'h00;
        hh_wrap = 1'b1;
      end else if (hh[3:0] == 4'd9) begin
        nxt_hh[3:0] = 4'd0;
        nxt_hh[7:4] = hh[7:4] + 4'd1;
      end else begin
        nxt_hh[3:0] = hh[3:0] + 4'd1;
      end
    end
  end

  always_comb begin
    load_valid = (set_ss[3:0] <= 4'd9) && (set_ss[7:4] <= 4'd5) &&
                 (set_mm[3:0] <= 4'd9) && (set_mm[7:4] <= 4'd5) &&
                 (set_hh[3:0] <= 4'd9) && (set_hh <= 8'h23);
  end

  // A load always takes priority over a coincident tick, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      set_err   <= 1'b0;
      if (set_load) begin
        if (load_valid) begin
          hh <= set_hh;
          mm <= set_mm;
          ss <= set_ss;
        end else begin
          set_err <= 1'b1;
        end
      end else if (tick_q && run) begin
        hh        <= nxt_hh;
        mm        <= nxt_mm;
        ss        <= nxt_ss;
        sec_pulse <= 1'b1;
        min_pulse <= ss_wrap;
        day_wrap  <= hh_wrap;
      end
    end
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter that consumes the divided slow clock produced by the clock divider. It treats that slow clock as a data input, never as a clock: it synchronises the signal into `clk`, detects each rising edge, and advances a 24-hour BCD HH:MM:SS count. It also provides a validated load port for setting the time and per-second, per-minute and day-wrap strobes for the display and alarm-compare logic.

## Interface
- `SYNC_STAGES`, 2: number of synchroniser flops on `slw_clk`; minimum 2.
- `clk`  in  1  system clock (100 MHz, 10 ns); the only clock in the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `slw_clk`  in  1  divided clock from the divider, sampled as data; one rising edge per second.
- `run`  in  1  1 = count seconds; 0 = hold the current time.
- `set_load`  in  1  single-cycle request to load `set_hh`/`set_mm`/`set_ss`.
- `set_hh`  in  8  BCD hours: [7:4] tens, [3:0] ones.
- `set_mm`  in  8  BCD minutes: [7:4] tens, [3:0] ones.
- `set_ss`  in  8  BCD seconds: [7:4] tens, [3:0] ones.
- `hh`  out  8  current hours in BCD, 00–23.
- `mm`  out  8  current minutes in BCD, 00–59.
- `ss`  out  8  current seconds in BCD, 00–59.
- `sec_pulse`  out  1  1-cycle strobe each time the time advances.
- `min_pulse`  out  1  1-cycle strobe when `ss` wraps from 59 to 00.
- `day_wrap`  out  1  1-cycle strobe when the time wraps from 23:59:59 to 00:00:00.
- `set_err`  out  1  1-cycle strobe when a load is rejected as invalid.

## Operation
- **Reset values:** all outputs reset to 0, so the time reads 00:00:00. All synchroniser flops and the edge-history flop reset to 0.
- **Synchroniser:** `SYNC_STAGES` flops in series carry `slw_clk` into the `clk` domain. An edge register holds the previous synchronised value.
- **Edge detection:**
  - `tick` = synchronised value high AND previous value low.
  - An arm counter blocks `tick` for the first `SYNC_STAGES`+1 cycles after reset release. A `slw_clk` that is already high at reset release therefore does not produce a tick.
- **Counting:** when `tick` is high and `run`=1, the time advances one second.
  - `ss` ones: 0..9, then carry into `ss` tens.
  - `ss` tens: 0..5, then carry into `mm`.
  - `mm` follows the same digit rules as `ss`, then carries into `hh`.
  - `hh` wraps from 23 to 00. When `hh` tens = 2, the ones digit wraps at 3.
  - All carries resolve within one cycle.
- **Run = 0:** ticks are discarded and not queued. Edge tracking continues while `run`=0, so raising `run` again does not create a spurious tick.
- **Load:**
  - A load is valid when all BCD digits are ≤ 9, the tens digits of `mm` and `ss` are ≤ 5, and `hh` ≤ 23.
  - A valid load replaces the full time.
  - An invalid load leaves the time unchanged and pulses `set_err`.
  - A load never asserts `sec_pulse`, `min_pulse` or `day_wrap`.
- **Load and tick in the same cycle:** the load wins and the tick is dropped. This applies whether the load is valid or invalid.
- **Reset during operation:** asserting `rst_n` low clears everything immediately, with no clock required. The first tick after release can only occur once the arm counter has expired.
- **Implementation:** one clocked process for the synchroniser, arm counter and edge register; one for the BCD counter chain and output strobes. No latches. No logic is clocked by `slw_clk`.

## Timing
- **Tick latency:** a rising edge of `slw_clk` that meets setup before clk edge E0 makes `tick` high in the cycle after edge E(`SYNC_STAGES`). With the default `SYNC_STAGES`=2, that is 3 cycles.
- **Strobe alignment:** the time outputs update, and `sec_pulse`/`min_pulse`/`day_wrap` assert, on the clk edge that ends the `tick` cycle. They are visible one cycle later, so total latency is `SYNC_STAGES`+2 cycles.
- **Load latency:** `set_load` sampled high at edge E updates `hh`/`mm`/`ss` (or asserts `set_err`) at E, visible in the following cycle.
- **Strobe width:** every strobe is exactly 1 `clk` cycle. A steady-high `slw_clk` produces exactly one tick.
- **Throughput:** a tick every cycle is not required. The minimum spacing between `slw_clk` rising edges is `SYNC_STAGES`+2 cycles; behaviour below that spacing is undefined.

## Test plan
- **Reset and arm window:** hold `slw_clk`=1 through reset release, keep it high 10 cycles → no `sec_pulse`, time stays 00:00:00. Then drive `slw_clk` low then high → exactly one `sec_pulse`, 4 cycles after the rise; `ss`=8'h01.
- **Minute carry:** load 00:00:59, apply one edge → time 00:01:00, `sec_pulse` and `min_pulse` together for 1 cycle, `day_wrap`=0.
- **Day wrap:** load 23:59:59, apply one edge → time 00:00:00, `sec_pulse`, `min_pulse` and `day_wrap` all high for the same single cycle.
- **Invalid loads:** apply `set_hh`=8'h24, then `set_mm`=8'h60, then `set_ss`=8'h0A on three separate loads → each gives a 1-cycle `set_err` and the time is unchanged. Then load 12:34:56 → time 12:34:56, `set_err`=0.
- **Load/tick collision and run:** arrange `set_load` (12:00:00) in the same cycle as `tick` → time 12:00:00 with no `sec_pulse`. Set `run`=0 and apply 3 edges → time unchanged. Set `run`=1 and apply 1 edge → 12:00:01.
- **Asynchronous reset mid-count:** at 05:17:42, pulse `rst_n` low for 3 ns between clk edges → outputs read 00:00:00 before the next clk edge, and all strobes are 0.
